// File: rtl/writeback_unit_pkg.sv
// Shared widths and the write-port request bundle
// for the writeback unit and its load queue.
package writeback_unit_pkg;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_W     = 5;
  localparam int LOAD_DEPTH_DEF = 4;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t        rd;
    logic [XLEN-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/writeback_unit_load_queue.sv
// In-order FIFO of outstanding load destinations with
// per-entry hit outputs for the decode query ports.
module wb_load_queue
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = LOAD_DEPTH_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  reg_addr_t        push_rd_i,
  input  logic             pop_i,
  input  reg_addr_t        rs1_i,
  input  reg_addr_t        rs2_i,
  input  reg_addr_t        rd_i,
  output reg_addr_t        head_rd_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [DEPTH-1:0] hit_rs1_o,
  output logic [DEPTH-1:0] hit_rs2_o,
  output logic [DEPTH-1:0] hit_rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  reg_addr_t        mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DEPTH-1:0] vld;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == CW'(DEPTH));
  assign head_rd_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_i);
    rd_ptr_d = rd_ptr_q + PW'(pop_i);
    cnt_d    = cnt_q + CW'(push_i) - CW'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) mem_q[wr_ptr_q] <= push_rd_i;
    end
  end

  // An entry is live when its distance from the head is below the count
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] off;
    assign off          = PW'(g) - rd_ptr_q;
    assign vld[g]       = ({1'b0, off} < cnt_q);
    assign hit_rs1_o[g] = vld[g] && (rs1_i != '0)
                          && (mem_q[g] == rs1_i);
    assign hit_rs2_o[g] = vld[g] && (rs2_i != '0)
                          && (mem_q[g] == rs2_i);
    assign hit_rd_o[g]  = vld[g] && (rd_i != '0)
                          && (mem_q[g] == rd_i);
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write port arbiter: load responses first,
// then a one-entry ALU skid, then fresh ALU results.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int LOAD_DEPTH = LOAD_DEPTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  output logic                  alu_ready,
  input  logic                  load_req_valid,
  input  logic [REG_ADDR_W-1:0] load_req_rd,
  output logic                  load_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [XLEN-1:0]       mem_resp_data,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [XLEN-1:0]       data,
  output logic                  reg_write,
  output logic                  resp_error
);

  wb_req_t skid_q, skid_d;
  logic    skid_v_q, skid_v_d;
  wb_req_t out_q, out_d;
  logic    we_q, we_d;
  logic    err_q, err_d;

  wb_req_t   alu_req, sel;
  logic      wr, pop, push, resp_ok, alu_fire;
  logic      q_empty, q_full;
  reg_addr_t head_rd;
  logic      skid_hit;

  logic [LOAD_DEPTH-1:0] hit_rs1, hit_rs2, hit_rd;

  assign load_req_ready = !q_full;
  assign push           = load_req_valid && load_req_ready;
  assign resp_ok        = mem_resp_valid && !q_empty;
  assign alu_ready      = !skid_v_q;
  assign alu_fire       = alu_valid && alu_ready;

  wb_load_queue #(.DEPTH(LOAD_DEPTH)) u_lq (
    .clk_i     (clock),
    .rst_i     (reset),
    .push_i    (push),
    .push_rd_i (load_req_rd),
    .pop_i     (pop),
    .rs1_i     (q_rs1),
    .rs2_i     (q_rs2),
    .rd_i      (q_rd),
    .head_rd_o (head_rd),
    .empty_o   (q_empty),
    .full_o    (q_full),
    .hit_rs1_o (hit_rs1),
    .hit_rs2_o (hit_rs2),
    .hit_rd_o  (hit_rd)
  );

  assign skid_hit = skid_v_q && (skid_q.rd != '0)
                    && ((skid_q.rd == q_rs1)
                    ||  (skid_q.rd == q_rs2));

  assign stall = (|hit_rs1) || (|hit_rs2)
                 || (|hit_rd) || skid_hit;

  always_comb begin
    alu_req.rd   = alu_rd;
    alu_req.data = alu_data;
    sel          = '0;
    wr           = 1'b0;
    pop          = 1'b0;
    skid_d       = skid_q;
    skid_v_d     = skid_v_q;
    if (resp_ok) begin
      sel.rd   = head_rd;
      sel.data = mem_resp_data;
      wr       = 1'b1;
      pop      = 1'b1;
      if (alu_fire) begin
        skid_d   = alu_req;
        skid_v_d = 1'b1;
      end
    end else if (skid_v_q) begin
      sel      = skid_q;
      wr       = 1'b1;
      skid_v_d = 1'b0;
    end else if (alu_fire) begin
      sel = alu_req;
      wr  = 1'b1;
    end
    out_d = wr ? sel : out_q;
    // x0 is consumed like any write but never strobed
    we_d  = wr && (sel.rd != '0);
    err_d = err_q || (mem_resp_valid && q_empty);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      out_q    <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      out_q    <= out_d;
      we_q     <= we_d;
      err_q    <= err_d;
    end
  end

  assign rd         = out_q.rd;
  assign data       = out_q.data;
  assign reg_write  = we_q;
  assign resp_error = err_q;

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: expected writes are
// queued at stimulus time and popped on each reg_write.
module tb_writeback_unit;
  import writeback_unit_pkg::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            alu_valid;
  reg_addr_t       alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            load_req_valid;
  reg_addr_t       load_req_rd;
  logic            load_req_ready;
  logic            mem_resp_valid;
  logic [XLEN-1:0] mem_resp_data;
  reg_addr_t       q_rs1, q_rs2, q_rd;
  logic            stall;
  reg_addr_t       rd;
  logic [XLEN-1:0] data;
  logic            reg_write;
  logic            resp_error;

  int n_chk  = 0;
  int n_pass = 0;

  wb_req_t sb [$];

  always #5 clock = ~clock;

  writeback_unit dut (
    .clock          (clock),
    .reset          (reset),
    .alu_valid      (alu_valid),
    .alu_rd         (alu_rd),
    .alu_data       (alu_data),
    .alu_ready      (alu_ready),
    .load_req_valid (load_req_valid),
    .load_req_rd    (load_req_rd),
    .load_req_ready (load_req_ready),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .q_rs1          (q_rs1),
    .q_rs2          (q_rs2),
    .q_rd           (q_rd),
    .stall          (stall),
    .rd             (rd),
    .data           (data),
    .reg_write      (reg_write),
    .resp_error     (resp_error)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_wr(input reg_addr_t r,
                           input logic [XLEN-1:0] d);
    wb_req_t e;
    e.rd   = r;
    e.data = d;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (reg_write === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr", {59'd0, rd}, 64'hFFFF);
      end else begin
        wb_req_t e;
        e = sb.pop_front();
        check("wb_rd", 64'(rd), 64'(e.rd));
        check("wb_data", 64'(data), 64'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    alu_valid      = 1'b0;
    alu_rd         = '0;
    alu_data       = '0;
    load_req_valid = 1'b0;
    load_req_rd    = '0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    q_rs1          = '0;
    q_rs2          = '0;
    q_rd           = '0;
    #12;
    check("rst_we", 64'(reg_write), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_data", 64'(data), 64'd0);
    check("rst_err", 64'(resp_error), 64'd0);
    check("rst_lready", 64'(load_req_ready), 64'd1);
    reset = 1'b0;
    step();

    // ALU only
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h1234;
    expect_wr(5'd5, 32'h1234);
    #1 check("alu_ready", 64'(alu_ready), 64'd1);
    step();
    alu_valid = 1'b0;
    check("alu_we", 64'(reg_write), 64'd1);
    check("alu_ready2", 64'(alu_ready), 64'd1);
    step();
    check("alu_one_cyc", 64'(reg_write), 64'd0);

    // single load with stall window
    load_req_valid = 1'b1;
    load_req_rd    = 5'd7;
    step();
    load_req_valid = 1'b0;
    q_rs1 = 5'd7;
    #1 check("ld_stall", 64'(stall), 64'd1);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hDEADBEEF;
    expect_wr(5'd7, 32'hDEADBEEF);
    #1 check("ld_stall_pop", 64'(stall), 64'd1);
    step();
    mem_resp_valid = 1'b0;
    #1 check("ld_nostall", 64'(stall), 64'd0);
    q_rs1 = '0;
    step();

    // response and ALU collide
    load_req_valid = 1'b1;
    load_req_rd    = 5'd3;
    step();
    load_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hAA;
    alu_valid      = 1'b1;
    alu_rd         = 5'd4;
    alu_data       = 32'hBB;
    expect_wr(5'd3, 32'hAA);
    expect_wr(5'd4, 32'hBB);
    step();
    mem_resp_valid = 1'b0;
    alu_valid      = 1'b0;
    q_rs2 = 5'd4;
    #1 check("col_ready", 64'(alu_ready), 64'd0);
    check("col_skid_stall", 64'(stall), 64'd1);
    step();
    q_rs2 = '0;
    #1 check("col_ready2", 64'(alu_ready), 64'd1);
    step();

    // fill the queue
    for (int i = 1; i <= 4; i++) begin
      load_req_valid = 1'b1;
      load_req_rd    = reg_addr_t'(i);
      #1 check("fill_ready", 64'(load_req_ready), 64'd1);
      step();
    end
    load_req_valid = 1'b0;
    #1 check("full_ready", 64'(load_req_ready), 64'd0);
    for (int i = 1; i <= 4; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = 32'(i * 10);
      expect_wr(reg_addr_t'(i), 32'(i * 10));
      if (i == 1) begin
        #1 check("full_pop_ready", 64'(load_req_ready), 64'd0);
      end
      step();
      if (i == 1) check("ready_back", 64'(load_req_ready), 64'd1);
    end
    mem_resp_valid = 1'b0;
    step();

    // x0 write is swallowed
    alu_valid = 1'b1;
    alu_rd    = '0;
    alu_data  = 32'hFF;
    step();
    alu_valid = 1'b0;
    check("x0_we", 64'(reg_write), 64'd0);
    step();

    // response with nothing outstanding
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h77;
    step();
    mem_resp_valid = 1'b0;
    check("err_set", 64'(resp_error), 64'd1);
    check("err_nowr", 64'(reg_write), 64'd0);
    step();

    // reset with two loads pending
    load_req_valid = 1'b1;
    load_req_rd    = 5'd9;
    step();
    load_req_rd    = 5'd10;
    step();
    load_req_valid = 1'b0;
    q_rd = 5'd9;
    #1 check("pend_stall", 64'(stall), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_err", 64'(resp_error), 64'd0);
    check("mid_rst_we", 64'(reg_write), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_rd", 64'(rd), 64'd0);
    step();
    reset = 1'b0;
    q_rd  = '0;
    step();

    // push and response into an empty queue together
    load_req_valid = 1'b1;
    load_req_rd    = 5'd12;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h99;
    step();
    load_req_valid = 1'b0;
    mem_resp_valid = 1'b0;
    q_rs1 = 5'd12;
    #1 check("pr_err", 64'(resp_error), 64'd1);
    check("pr_stall", 64'(stall), 64'd1);
    q_rs1 = '0;
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h55;
    expect_wr(5'd12, 32'h55);
    step();
    mem_resp_valid = 1'b0;
    step();

    // back-to-back ALU burst
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_rd    = reg_addr_t'(i + 1);
      alu_data  = $urandom;
      expect_wr(alu_rd, alu_data);
      step();
    end
    alu_valid = 1'b0;
    step();
    step();

    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
